// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states and requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port not granted last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = (req_i == 2'b11) ? ~last_grant_i : req_i[1];
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises CPU and debug-loader accesses onto the single unified memory,
// inserting MEM_LAT wait states and stalling the core until its access completes.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CPU_Req,
  input  logic          CPU_We,
  input  logic [AW-1:0] CPU_Adr,
  input  logic [DW-1:0] CPU_WD,
  output logic [DW-1:0] CPU_RD,
  output logic          CPU_Ack,
  output logic          CPU_Stall,
  input  logic          DBG_Req,
  input  logic          DBG_We,
  input  logic [AW-1:0] DBG_Adr,
  input  logic [DW-1:0] DBG_WD,
  output logic [DW-1:0] DBG_RD,
  output logic          DBG_Ack,
  output logic          MEM_En,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_Adr,
  output logic [DW-1:0] MEM_WD,
  input  logic [DW-1:0] MEM_RD,
  output logic          Grant
);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             we_q, we_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [DW-1:0]    wd_q, wd_d;
  logic [DW-1:0]    cpu_rd_q, cpu_rd_d;
  logic [DW-1:0]    dbg_rd_q, dbg_rd_d;
  logic             en_q, en_d;
  logic             mem_we_q, mem_we_d;
  logic             cpu_ack_q, cpu_ack_d;
  logic             dbg_ack_q, dbg_ack_d;
  logic             arb_valid, arb_winner;

  rr_arb2 u_rr_arb2 (
    .req_i        ({DBG_Req, CPU_Req}),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .winner_o     (arb_winner)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    adr_d        = adr_q;
    wd_d         = wd_q;
    cpu_rd_d     = cpu_rd_q;
    dbg_rd_d     = dbg_rd_q;
    en_d         = en_q;
    mem_we_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    dbg_ack_d    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (arb_valid) begin
          state_d      = ARB_ACCESS;
          grant_d      = arb_winner;
          last_grant_d = arb_winner;
          adr_d        = (arb_winner == REQ_DBG) ? DBG_Adr : CPU_Adr;
          wd_d         = (arb_winner == REQ_DBG) ? DBG_WD  : CPU_WD;
          we_d         = (arb_winner == REQ_DBG) ? DBG_We  : CPU_We;
          cnt_d        = CNT_W'(MEM_LAT);
          en_d         = 1'b1;
          // Write strobe lives only in the first access cycle.
          mem_we_d     = (arb_winner == REQ_DBG) ? DBG_We : CPU_We;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!we_q) begin
            if (grant_q == REQ_DBG) dbg_rd_d = MEM_RD;
            else                    cpu_rd_d = MEM_RD;
          end
          state_d   = ARB_DONE;
          en_d      = 1'b0;
          cpu_ack_d = (grant_q == REQ_CPU);
          dbg_ack_d = (grant_q == REQ_DBG);
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= '0;
      grant_q      <= REQ_CPU;
      last_grant_q <= REQ_DBG;  // CPU wins the first tie
      we_q         <= 1'b0;
      adr_q        <= '0;
      wd_q         <= '0;
      cpu_rd_q     <= '0;
      dbg_rd_q     <= '0;
      en_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      wd_q         <= wd_d;
      cpu_rd_q     <= cpu_rd_d;
      dbg_rd_q     <= dbg_rd_d;
      en_q         <= en_d;
      mem_we_q     <= mem_we_d;
      cpu_ack_q    <= cpu_ack_d;
      dbg_ack_q    <= dbg_ack_d;
    end
  end

  always_comb begin
    CPU_RD    = cpu_rd_q;
    CPU_Ack   = cpu_ack_q;
    CPU_Stall = CPU_Req & ~cpu_ack_q;
    DBG_RD    = dbg_rd_q;
    DBG_Ack   = dbg_ack_q;
    MEM_En    = en_q;
    MEM_WE    = mem_we_q;
    MEM_Adr   = adr_q;
    MEM_WD    = wd_q;
    Grant     = grant_q;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: instances at MEM_LAT 1, 0 and 15 share the
// requester inputs, each with its own memory model; sel picks which one is observed.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_adr = '0, cpu_wd = '0, dbg_adr = '0, dbg_wd = '0;
  int          sel = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    logic [31:0] cpu_rd, dbg_rd, m_adr, m_wd, m_rd;
    logic        cpu_ack, cpu_stall, dbg_ack, m_en, m_we, grant;
    logic [31:0] mem [64];

    initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[4] = 32'hDEADBEEF;
    end
    assign m_rd = mem[m_adr[7:2]];
    always @(posedge clk) if (m_en && m_we) mem[m_adr[7:2]] <= m_wd;

    unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L), .CNT_W(4)) u_dut (
      .CLK(clk), .RESET(rst),
      .CPU_Req(cpu_req), .CPU_We(cpu_we), .CPU_Adr(cpu_adr), .CPU_WD(cpu_wd),
      .CPU_RD(cpu_rd), .CPU_Ack(cpu_ack), .CPU_Stall(cpu_stall),
      .DBG_Req(dbg_req), .DBG_We(dbg_we), .DBG_Adr(dbg_adr), .DBG_WD(dbg_wd),
      .DBG_RD(dbg_rd), .DBG_Ack(dbg_ack),
      .MEM_En(m_en), .MEM_WE(m_we), .MEM_Adr(m_adr), .MEM_WD(m_wd), .MEM_RD(m_rd),
      .Grant(grant)
    );
  end

  logic [31:0] o_cpu_rd, o_dbg_rd, o_m_adr, o_m_wd;
  logic        o_cpu_ack, o_cpu_stall, o_dbg_ack, o_m_en, o_m_we, o_grant;
  assign o_cpu_rd    = (sel == 0) ? g_dut[0].cpu_rd    : (sel == 1) ? g_dut[1].cpu_rd    : g_dut[2].cpu_rd;
  assign o_dbg_rd    = (sel == 0) ? g_dut[0].dbg_rd    : (sel == 1) ? g_dut[1].dbg_rd    : g_dut[2].dbg_rd;
  assign o_m_adr     = (sel == 0) ? g_dut[0].m_adr     : (sel == 1) ? g_dut[1].m_adr     : g_dut[2].m_adr;
  assign o_m_wd      = (sel == 0) ? g_dut[0].m_wd      : (sel == 1) ? g_dut[1].m_wd      : g_dut[2].m_wd;
  assign o_cpu_ack   = (sel == 0) ? g_dut[0].cpu_ack   : (sel == 1) ? g_dut[1].cpu_ack   : g_dut[2].cpu_ack;
  assign o_cpu_stall = (sel == 0) ? g_dut[0].cpu_stall : (sel == 1) ? g_dut[1].cpu_stall : g_dut[2].cpu_stall;
  assign o_dbg_ack   = (sel == 0) ? g_dut[0].dbg_ack   : (sel == 1) ? g_dut[1].dbg_ack   : g_dut[2].dbg_ack;
  assign o_m_en      = (sel == 0) ? g_dut[0].m_en      : (sel == 1) ? g_dut[1].m_en      : g_dut[2].m_en;
  assign o_m_we      = (sel == 0) ? g_dut[0].m_we      : (sel == 1) ? g_dut[1].m_we      : g_dut[2].m_we;
  assign o_grant     = (sel == 0) ? g_dut[0].grant     : (sel == 1) ? g_dut[1].grant     : g_dut[2].grant;

  // One complete access: raise Req, wait (bounded) for Ack, drop Req the cycle after.
  task automatic xact(input bit dbg, input bit we, input logic [31:0] adr, input logic [31:0] wd,
                      output int waits, output int stalls, output int we_n,
                      output logic [31:0] we_adr, output logic [31:0] rd);
    @(posedge clk); #1;
    if (dbg) begin dbg_req = 1; dbg_we = we; dbg_adr = adr; dbg_wd = wd; end
    else     begin cpu_req = 1; cpu_we = we; cpu_adr = adr; cpu_wd = wd; end
    waits = 0; stalls = 0; we_n = 0; we_adr = '0; rd = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_m_we) begin we_n++; we_adr = o_m_adr; end
      if (o_cpu_stall) stalls++;
      if (dbg ? o_dbg_ack : o_cpu_ack) begin rd = dbg ? o_dbg_rd : o_cpu_rd; break; end
      waits++;
    end
    @(posedge clk); #1;
    cpu_req = 0; dbg_req = 0;
  endtask

  task automatic do_reset();
    rst = 1; cpu_req = 0; dbg_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk);
    checks++; if (o_m_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", o_m_en); end
    checks++; if (o_m_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", o_m_we); end
    checks++; if (o_m_adr !== 32'h0) begin errors++; $display("FAIL reset_adr got %h want 0", o_m_adr); end
    checks++; if (o_m_wd !== 32'h0) begin errors++; $display("FAIL reset_wd got %h want 0", o_m_wd); end
    checks++; if (o_cpu_rd !== 32'h0 || o_dbg_rd !== 32'h0) begin
      errors++; $display("FAIL reset_rd got %h/%h want 0/0", o_cpu_rd, o_dbg_rd); end
    checks++; if (o_cpu_ack !== 1'b0 || o_dbg_ack !== 1'b0) begin
      errors++; $display("FAIL reset_ack got %b/%b want 0/0", o_cpu_ack, o_dbg_ack); end
    checks++; if (o_grant !== 1'b0) begin errors++; $display("FAIL reset_grant got %b want 0", o_grant); end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_cpu_read();
    int w, s, wn; logic [31:0] wa, rd;
    xact(0, 0, 32'h10, 32'h0, w, s, wn, wa, rd);
    checks++; if (s != 3) begin errors++; $display("FAIL cpu_read_stall got %0d want 3", s); end
    checks++; if (w != 3) begin errors++; $display("FAIL cpu_read_latency got %0d want 3", w); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_read_data got %h want deadbeef", rd); end
    @(negedge clk);
    checks++; if (o_cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_ack_pulse got %b want 0", o_cpu_ack); end
  endtask

  task automatic test_dbg_write();
    int w, s, wn; logic [31:0] wa, rd;
    xact(1, 1, 32'h40, 32'h12345678, w, s, wn, wa, rd);
    checks++; if (wn != 1) begin errors++; $display("FAIL dbg_write_we_cycles got %0d want 1", wn); end
    checks++; if (wa !== 32'h40) begin errors++; $display("FAIL dbg_write_adr got %h want 40", wa); end
    checks++; if (w != 3) begin errors++; $display("FAIL dbg_write_latency got %0d want 3", w); end
    xact(0, 0, 32'h40, 32'h0, w, s, wn, wa, rd);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL dbg_write_readback got %h want 12345678", rd); end
  endtask

  task automatic test_round_robin();
    int n = 0, n_double = 0;
    logic [3:0] seq = '0;
    cpu_adr = 32'h10; cpu_we = 0; dbg_adr = 32'h40; dbg_we = 0;
    cpu_req = 1; dbg_req = 1; rst = 1;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (o_cpu_ack && o_dbg_ack) n_double++;
      if (o_cpu_ack) begin seq[n] = 1'b0; n++; end
      else if (o_dbg_ack) begin seq[n] = 1'b1; n++; end
    end
    @(posedge clk); #1 cpu_req = 0; dbg_req = 0;
    checks++; if (n != 4) begin errors++; $display("FAIL rr_ack_count got %0d want 4", n); end
    checks++; if (seq !== 4'b1010) begin errors++; $display("FAIL rr_order got %b want 1010", seq); end
    checks++; if (n_double != 0) begin errors++; $display("FAIL rr_double_ack got %0d want 0", n_double); end
    checks++; if (o_cpu_rd !== 32'hDEADBEEF || o_dbg_rd !== 32'h12345678) begin
      errors++; $display("FAIL rr_data got %h/%h want deadbeef/12345678", o_cpu_rd, o_dbg_rd); end
  endtask

  task automatic test_reset_mid_access();
    int n_ack = 0, w, s, wn; logic [31:0] wa, rd;
    @(posedge clk); #1 cpu_req = 1; cpu_we = 0; cpu_adr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    checks++; if (o_m_en !== 1'b1) begin errors++; $display("FAIL midrst_en_before got %b want 1", o_m_en); end
    rst = 1;
    #1;
    checks++; if (o_m_en !== 1'b0) begin errors++; $display("FAIL midrst_en got %b want 0", o_m_en); end
    checks++; if (o_grant !== 1'b0) begin errors++; $display("FAIL midrst_grant got %b want 0", o_grant); end
    @(posedge clk); #1 rst = 0; cpu_req = 0;
    repeat (5) begin @(negedge clk); if (o_cpu_ack || o_dbg_ack) n_ack++; end
    checks++; if (n_ack != 0) begin errors++; $display("FAIL midrst_no_ack got %0d want 0", n_ack); end
    xact(0, 0, 32'h10, 32'h0, w, s, wn, wa, rd);
    checks++; if (w != 3 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL midrst_reissue got lat %0d data %h want 3 deadbeef", w, rd); end
  endtask

  task automatic test_adr_change();
    int n_ack = 0, bad_adr = 0; logic [31:0] rd = '0;
    @(posedge clk); #1 cpu_req = 1; cpu_we = 0; cpu_adr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 cpu_adr = 32'h10; cpu_req = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_m_en && o_m_adr !== 32'h40) bad_adr++;
      if (o_cpu_ack) begin n_ack++; rd = o_cpu_rd; end
    end
    checks++; if (o_m_adr !== 32'h40) begin errors++; $display("FAIL adrchg_latched got %h want 40", o_m_adr); end
    checks++; if (bad_adr != 0) begin errors++; $display("FAIL adrchg_during got %0d want 0", bad_adr); end
    checks++; if (n_ack != 1) begin errors++; $display("FAIL adrchg_ack got %0d want 1", n_ack); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL adrchg_data got %h want 12345678", rd); end
  endtask

  task automatic test_sweep(input int s, input int lat);
    logic [31:0] ref_mem [8];
    bit          valid [8];
    int w, st, wn; logic [31:0] wa, rd, wd;
    bit dbg, we; int idx;
    sel = s;
    for (int i = 0; i < 8; i++) begin valid[i] = 0; ref_mem[i] = '0; end
    do_reset();
    for (int n = 0; n < 100; n++) begin
      dbg = 1'($urandom_range(1));
      idx = int'($urandom_range(7));
      we  = !valid[idx] || ($urandom_range(1) == 1);
      wd  = $urandom;
      xact(dbg, we, 32'h80 + 32'(idx * 4), wd, w, st, wn, wa, rd);
      checks++; if (w != lat + 2) begin
        errors++; $display("FAIL sweep%0d_latency n=%0d got %0d want %0d", lat, n, w, lat + 2); end
      if (we) begin
        ref_mem[idx] = wd; valid[idx] = 1;
      end else begin
        checks++; if (rd !== ref_mem[idx]) begin
          errors++; $display("FAIL sweep%0d_data n=%0d got %h want %h", lat, n, rd, ref_mem[idx]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_round_robin();
    test_reset_mid_access();
    test_adr_change();
    test_sweep(1, 0);
    test_sweep(2, 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
